uart_packet_parser: RTL and testbench



---
 rtl/uart_packet_parser.sv | 132 +++++++++++++
 tb/tb_uart_packet_parser.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_parser.sv
// Assembles sync + payload + XOR-checksum frames from a UART byte stream into one wide word.
// Bad checksums and inter-byte stalls drop the frame and raise a one-cycle error pulse.
module uart_packet_parser #(
  parameter int          PAYLOAD_BYTES  = 6,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 65000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       pkt_valid,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
  output logic                       checksum_err,
  output logic                       timeout_err,
  output logic [15:0]                pkt_count,
  output logic [7:0]                 err_count
);

  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Handshake: a byte is consumed in every cycle byte_valid is high; there is no backpressure.
  state_t          state, state_next;
  logic [IW-1:0]   index, index_next;
  logic [7:0]      xor_acc, xor_next;
  logic [TW-1:0]   timer, timer_next;
  logic [PW-1:0]   shadow, shadow_next;
  logic [PW-1:0]   pkt_data_next;
  logic            pkt_valid_next, checksum_err_next, timeout_err_next;
  logic [15:0]     pkt_count_next;
  logic [7:0]      err_count_next;
  logic [7:0]      err_count_inc;

  assign err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      index        <= '0;
      xor_acc      <= '0;
      timer        <= '0;
      shadow       <= '0;
      pkt_data     <= '0;
      pkt_valid    <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      pkt_count    <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_next;
      index        <= index_next;
      xor_acc      <= xor_next;
      timer        <= timer_next;
      shadow       <= shadow_next;
      pkt_data     <= pkt_data_next;
      pkt_valid    <= pkt_valid_next;
      checksum_err <= checksum_err_next;
      timeout_err  <= timeout_err_next;
      pkt_count    <= pkt_count_next;
      err_count    <= err_count_next;
    end
  end

  always_comb begin
    state_next        = state;
    index_next        = index;
    xor_next          = xor_acc;
    timer_next        = timer;
    shadow_next       = shadow;
    pkt_data_next     = pkt_data;
    pkt_valid_next    = 1'b0;
    checksum_err_next = 1'b0;
    timeout_err_next  = 1'b0;
    pkt_count_next    = pkt_count;
    err_count_next    = err_count;

    case (state)
      HUNT: begin
        timer_next = '0;
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_next = PAYLOAD;
          index_next = '0;
          xor_next   = '0;
        end
      end
      default: begin
        // PAYLOAD and CHECK share the inter-byte timer; a byte in the last timer cycle wins.
        if (byte_valid) begin
          timer_next = '0;
          if (state == PAYLOAD) begin
            shadow_next[{index, 3'b000} +: 8] = byte_data;
            xor_next = xor_acc ^ byte_data;
            if (index == IDX_LAST) begin
              index_next = '0;
              state_next = CHECK;
            end else begin
              index_next = index + 1'b1;
            end
          end else begin
            state_next = HUNT;
            if (byte_data == xor_acc) begin
              pkt_data_next  = shadow;
              pkt_valid_next = 1'b1;
              pkt_count_next = pkt_count + 16'd1;
            end else begin
              checksum_err_next = 1'b1;
              err_count_next    = err_count_inc;
            end
          end
        end else if (timer == T_LAST) begin
          timer_next       = '0;
          state_next       = HUNT;
          timeout_err_next = 1'b1;
          err_count_next   = err_count_inc;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Bench for uart_packet_parser: table vectors, directed corner sequences and random traffic
// checked against a frame-level model through an expected-event queue stamped with cycle numbers.
module tb_uart_packet_parser;

  localparam int P = 6;
  localparam int T = 100;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int W = 2 + 48 + 32;

  logic          clk;
  logic          rst_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          pkt_valid;
  logic [8*P-1:0] pkt_data;
  logic          checksum_err;
  logic          timeout_err;
  logic [15:0]   pkt_count;
  logic [7:0]    err_count;

  uart_packet_parser #(
    .PAYLOAD_BYTES (P),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .checksum_err(checksum_err),
    .timeout_err (timeout_err),
    .pkt_count   (pkt_count),
    .err_count   (err_count)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference model: event kinds 1=packet, 2=checksum error, 3=timeout
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_frame[$];
  bit           m_in_frame;
  int           m_gap;
  logic [15:0]  m_pkt_count;
  int           m_err_count;

  function automatic logic [W-1:0] mk_ev(input logic [1:0] kind, input logic [47:0] d,
                                         input int unsigned stamp);
    return {kind, d, stamp};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_frame.delete();
    m_in_frame  = 0;
    m_gap       = 0;
    m_pkt_count = 0;
    m_err_count = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0]  x;
    logic [47:0] d;
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1;
        m_frame.delete();
        m_gap = 0;
      end
    end else begin
      m_frame.push_back(b);
      m_gap = 0;
      if (m_frame.size() == P + 1) begin
        x = 8'h00;
        d = '0;
        for (int k = 0; k < P; k++) begin
          x = x ^ m_frame[k];
          d = d | (48'(m_frame[k]) << (8 * k));
        end
        if (x == m_frame[P]) begin
          exp_q.push_back(mk_ev(2'd1, d, cyc + 1));
          m_pkt_count++;
        end else begin
          exp_q.push_back(mk_ev(2'd2, 48'h0, cyc + 1));
          if (m_err_count < 255) m_err_count++;
        end
        m_in_frame = 0;
      end
    end
  endtask

  task automatic model_idle();
    if (m_in_frame) begin
      m_gap++;
      if (m_gap == T) begin
        exp_q.push_back(mk_ev(2'd3, 48'h0, cyc + 1));
        if (m_err_count < 255) m_err_count++;
        m_in_frame = 0;
      end
    end
  endtask

  // Driver tasks: always entered and left at a negedge
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    model_byte(b);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      model_idle();
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [47:0] payload, input logic [7:0] corrupt);
    logic [7:0] x;
    x = 8'h00;
    send_byte(SYNC);
    for (int k = 0; k < P; k++) begin
      x = x ^ payload[8*k +: 8];
      send_byte(payload[8*k +: 8]);
    end
    send_byte(x ^ corrupt);
  endtask

  task automatic check_counts(input string tag);
    idle(2);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(m_pkt_count));
    chk({tag, "_err_count"}, 64'(err_count), 64'(m_err_count));
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every pulse must match the head of the expected queue, including its cycle
  always @(negedge clk) begin
    logic [1:0]   kind;
    logic [W-1:0] e;
    if (rst_n && (pkt_valid || checksum_err || timeout_err)) begin
      kind = pkt_valid ? 2'd1 : (checksum_err ? 2'd2 : 2'd3);
      chk("pulse_exclusive", 64'(int'(pkt_valid) + int'(checksum_err) + int'(timeout_err)), 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual kind=%0d required=none (cycle %0d)", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e[W-1 -: 2]));
        chk("event_data", 64'(pkt_valid ? pkt_data : 48'h0), 64'(e[79:32]));
        chk("event_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  typedef struct {
    logic [63:0] frame;
    logic        exp_pkt;
    logic        exp_chk;
    logic [47:0] exp_data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    logic [47:0] pl;
    int r;

    tbl[0] = '{64'hA5_01_02_03_04_05_06_07, 1'b1, 1'b0, 48'h060504030201};
    tbl[1] = '{64'hA5_01_02_03_04_05_06_08, 1'b0, 1'b1, 48'h060504030201};
    tbl[2] = '{64'hA5_10_20_30_40_50_60_70, 1'b1, 1'b0, 48'h605040302010};
    tbl[3] = '{64'hA5_FF_00_FF_00_FF_00_00, 1'b0, 1'b1, 48'h605040302010};
    tbl[4] = '{64'hA5_A5_A5_A5_A5_A5_A5_00, 1'b1, 1'b0, 48'hA5A5A5A5A5A5};

    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_reset();
    #3;
    chk("reset_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("reset_pkt_data", 64'(pkt_data), 64'd0);
    chk("reset_errs", 64'({checksum_err, timeout_err}), 64'd0);
    chk("reset_counts", 64'({pkt_count, err_count}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Table vectors: outputs checked on the negedge right after the checksum byte is sampled
    for (int i = 0; i < 5; i++) begin
      for (int j = 7; j >= 0; j--) send_byte(tbl[i].frame[8*j +: 8]);
      chk($sformatf("tbl%0d_pkt_valid", i), 64'(pkt_valid), 64'(tbl[i].exp_pkt));
      chk($sformatf("tbl%0d_checksum_err", i), 64'(checksum_err), 64'(tbl[i].exp_chk));
      chk($sformatf("tbl%0d_pkt_data", i), 64'(pkt_data), 64'(tbl[i].exp_data));
      idle(1);
    end
    check_counts("tbl");

    // Leading garbage then a frame full of sync values
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    for (int k = 0; k < 7; k++) send_byte(SYNC);
    send_byte(8'h00);
    chk("garbage_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("garbage_pkt_data", 64'(pkt_data), 64'hA5A5A5A5A5A5);
    check_counts("garbage");

    // Timeout: pulse exactly T cycles after the last byte
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h02);
    n = 0;
    while (!timeout_err && n < T + 10) begin
      idle(1);
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(T));
    send_frame(48'h0C0B0A090807, 8'h00);
    chk("after_timeout_pkt_valid", 64'(pkt_valid), 64'd1);
    check_counts("timeout");

    // A byte in the last timer cycle is accepted and no timeout fires
    send_byte(SYNC); send_byte(8'h11);
    idle(T - 1);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66);
    chk("late_byte_pkt_valid", 64'(pkt_valid), 64'd1);
    chk("late_byte_pkt_data", 64'(pkt_data), 64'h665544332211);
    check_counts("late_byte");

    // Asynchronous reset mid-frame
    send_byte(SYNC); send_byte(8'h01); send_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("async_rst_counts", 64'({pkt_count, err_count}), 64'd0);
    chk("async_rst_pulses", 64'({pkt_valid, checksum_err, timeout_err}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    idle(T + 5);
    send_frame(48'h060504030201, 8'h00);
    chk("post_reset_pkt_data", 64'(pkt_data), 64'h060504030201);
    check_counts("post_reset");

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      pl = {$urandom, $urandom};
      if (r < 2) send_byte(8'($urandom));
      else if (r < 6) send_frame(pl, 8'h00);
      else if (r < 8) send_frame(pl, 8'($urandom_range(1, 255)));
      else if (r == 8) begin
        send_byte(SYNC);
        n = $urandom_range(0, P);
        for (int k = 0; k < n; k++) send_byte(8'($urandom));
        idle($urandom_range(T - 3, T + 3));
      end else idle($urandom_range(0, 5));
    end
    idle(T + 5);
    check_counts("random");

    // Back-to-back frames and counter limits
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) send_frame({$urandom, $urandom}, 8'h00);
    check_counts("b2b_good");
    chk("b2b_pkt_count_300", 64'(pkt_count), 64'd300);
    for (int i = 0; i < 260; i++) send_frame({$urandom, $urandom}, 8'($urandom_range(1, 255)));
    check_counts("b2b_bad");
    chk("err_count_saturated", 64'(err_count), 64'hFF);

    idle(3);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
